// File: rtl/bus_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : bus_scheduler
// Brief    : Time-division bus scheduler: fixed frames of FRAME_CYCLES clocks,
//            four frames per group, each frame owned by the 6502 or one DMA
//            requester. Define BUS_SCHED_STARVE_EN for requester-1 anti-starvation.
// Revision : 1.0  initial release
// ============================================================================
module bus_scheduler #(
    parameter int FRAME_CYCLES  = 16,
    parameter int STARVE_FRAMES = 4
) (
    input  logic                            sys_clock_i,
    input  logic                            sys_reset_n_i,
    input  logic [1:0]                      speed_i,
    input  logic                            cpu_pause_i,
    output logic                            cpu_paused_o,
    output logic                            cpu_grant_o,
    input  logic [1:0]                      dma_req_i,
    output logic [1:0]                      dma_grant_o,
    output logic                            frame_start_o,
    output logic [$clog2(FRAME_CYCLES)-1:0] frame_cycle_o
);

    localparam int              C_CW   = $clog2(FRAME_CYCLES);
    localparam logic [C_CW-1:0] C_LAST = C_CW'(FRAME_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_PAUSED = 2'd2
    } pause_state_t;

    generate
        if ((FRAME_CYCLES < 16) || ((FRAME_CYCLES & (FRAME_CYCLES - 1)) != 0)) begin : g_bad_frame
            $error("bus_scheduler: FRAME_CYCLES must be a power of two and >= 16");
        end
        if (STARVE_FRAMES < 1) begin : g_bad_starve
            $error("bus_scheduler: STARVE_FRAMES must be >= 1");
        end
    endgenerate

    logic [C_CW-1:0] r_cycle_count;
    logic [1:0]      r_frame_idx;
    logic [1:0]      r_speed;
    pause_state_t    r_state;

    logic            w_last;
    logic [1:0]      w_next_idx;
    logic [1:0]      w_speed_eff;
    logic [1:0]      w_cpu_frames;
    logic            w_cpu_next;
    logic [1:0]      w_dma_next;

`ifdef BUS_SCHED_STARVE_EN
    localparam int              C_SW         = $clog2(STARVE_FRAMES + 1);
    localparam logic [C_SW-1:0] C_STARVE_MAX = C_SW'(STARVE_FRAMES);
    logic [C_SW-1:0] r_starve;
    logic            w_starved;
`endif

    always_comb begin
        w_last      = (r_cycle_count == C_LAST);
        w_next_idx  = r_frame_idx + 2'd1;
        // The first frame of a group sees the fresh speed; the rest use the latched one.
        w_speed_eff = (w_next_idx == 2'd0) ? speed_i : r_speed;
        case (w_speed_eff)
            2'd0:    w_cpu_frames = 2'd1;
            2'd1:    w_cpu_frames = 2'd2;
            default: w_cpu_frames = 2'd3;
        endcase
        w_cpu_next = (w_next_idx < w_cpu_frames) && (r_state == ST_RUN) && !cpu_pause_i;
        w_dma_next = 2'b00;
`ifdef BUS_SCHED_STARVE_EN
        w_starved  = (r_starve == C_STARVE_MAX);
        if (!w_cpu_next) begin
            if (w_starved && dma_req_i[1]) w_dma_next = 2'b10;
            else if (dma_req_i[0])         w_dma_next = 2'b01;
            else if (dma_req_i[1])         w_dma_next = 2'b10;
        end
`else
        if (!w_cpu_next) begin
            if (dma_req_i[0])      w_dma_next = 2'b01;
            else if (dma_req_i[1]) w_dma_next = 2'b10;
        end
`endif
    end

    always_ff @(posedge sys_clock_i or negedge sys_reset_n_i) begin
        if (!sys_reset_n_i) begin
            r_cycle_count <= '0;
            r_frame_idx   <= 2'd3;
            r_speed       <= 2'd0;
            r_state       <= ST_RUN;
            cpu_paused_o  <= 1'b0;
            cpu_grant_o   <= 1'b0;
            dma_grant_o   <= 2'b00;
            frame_start_o <= 1'b0;
        end else begin
            r_cycle_count <= r_cycle_count + 1'b1;
            frame_start_o <= w_last;
            cpu_grant_o   <= w_last && w_cpu_next;
            if (w_last) begin
                r_frame_idx <= w_next_idx;
                dma_grant_o <= w_dma_next;
                if (w_next_idx == 2'd0) begin
                    r_speed <= speed_i;
                end
            end

            case (r_state)
                ST_RUN: begin
                    if (cpu_pause_i) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!cpu_pause_i) begin
                        r_state <= ST_RUN;
                    end else if (w_last) begin
                        // The frame being drained ends here; the next one is never CPU.
                        r_state      <= ST_PAUSED;
                        cpu_paused_o <= 1'b1;
                    end
                end
                ST_PAUSED: begin
                    if (!cpu_pause_i) begin
                        r_state      <= ST_RUN;
                        cpu_paused_o <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_RUN;
                    cpu_paused_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef BUS_SCHED_STARVE_EN
    always_ff @(posedge sys_clock_i or negedge sys_reset_n_i) begin
        if (!sys_reset_n_i) begin
            r_starve <= '0;
        end else if (!dma_req_i[1]) begin
            r_starve <= '0;
        end else if (w_last && !w_cpu_next) begin
            if (w_dma_next[1])              r_starve <= '0;
            else if (r_starve != C_STARVE_MAX) r_starve <= r_starve + 1'b1;
        end
    end
`endif

    assign frame_cycle_o = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_bus_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_scheduler
// Brief    : Directed self-checking bench for bus_scheduler (16-cycle frames).
// Revision : 1.0  initial release
// ============================================================================
module tb_bus_scheduler;

    logic       clk;
    logic       rst_n;
    logic [1:0] speed;
    logic       pause;
    logic       paused;
    logic       cpu_grant;
    logic [1:0] req;
    logic [1:0] dma_grant;
    logic       fstart;
    logic [3:0] fcycle;

    int total = 0;
    int bad   = 0;

    bus_scheduler #(
        .FRAME_CYCLES  (16),
        .STARVE_FRAMES (4)
    ) dut (
        .sys_clock_i   (clk),
        .sys_reset_n_i (rst_n),
        .speed_i       (speed),
        .cpu_pause_i   (pause),
        .cpu_paused_o  (paused),
        .cpu_grant_o   (cpu_grant),
        .dma_req_i     (req),
        .dma_grant_o   (dma_grant),
        .frame_start_o (fstart),
        .frame_cycle_o (fcycle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Release at a falling edge: the next rising edge is clock 1 of the idle frame.
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        speed = 2'd0; pause = 1'b0; req = 2'b00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (cpu_grant !== 1'b0)   begin bad++; $display("FAIL reset_cpu got=%b exp=0", cpu_grant); end
        total++; if (dma_grant !== 2'b00)  begin bad++; $display("FAIL reset_dma got=%b exp=00", dma_grant); end
        total++; if (fstart !== 1'b0)      begin bad++; $display("FAIL reset_fstart got=%b exp=0", fstart); end
        total++; if (fcycle !== 4'd0)      begin bad++; $display("FAIL reset_fcycle got=%0d exp=0", fcycle); end
        total++; if (paused !== 1'b0)      begin bad++; $display("FAIL reset_paused got=%b exp=0", paused); end
        rst_n = 1'b1;
    endtask

    task automatic test_speed0();
        logic       e_cpu;
        logic       e_fs;
        logic [3:0] e_cyc;
        speed = 2'd0; pause = 1'b0; req = 2'b00;
        do_reset();
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            e_cpu = (k >= 16) && (((k - 16) % 64) == 0);
            e_fs  = ((k % 16) == 0);
            e_cyc = 4'(k % 16);
            total++; if (cpu_grant !== e_cpu) begin bad++; $display("FAIL speed0_cpu k=%0d got=%b exp=%b", k, cpu_grant, e_cpu); end
            total++; if (dma_grant !== 2'b00) begin bad++; $display("FAIL speed0_dma k=%0d got=%b exp=00", k, dma_grant); end
            total++; if (fstart !== e_fs)     begin bad++; $display("FAIL speed0_fstart k=%0d got=%b exp=%b", k, fstart, e_fs); end
            total++; if (fcycle !== e_cyc)    begin bad++; $display("FAIL speed0_fcycle k=%0d got=%0d exp=%0d", k, fcycle, e_cyc); end
        end
    endtask

    // Speed 2 with video requests: CPU,CPU,CPU,DMA0; request dropped mid-frame keeps the grant.
    task automatic test_speed2_dma0();
        int         f;
        int         idx;
        logic       e_cpu;
        logic [1:0] e_dma;
        speed = 2'd2; pause = 1'b0; req = 2'b01;
        do_reset();
        for (int k = 1; k <= 160; k++) begin
            @(negedge clk);
            f   = k / 16;
            idx = (f - 1) % 4;
            e_cpu = (f >= 1) && ((k % 16) == 0) && (idx < 3);
            e_dma = ((f >= 1) && (idx == 3) && (f < 8)) ? 2'b01 : 2'b00;
            total++; if (cpu_grant !== e_cpu) begin bad++; $display("FAIL speed2_cpu k=%0d got=%b exp=%b", k, cpu_grant, e_cpu); end
            total++; if (dma_grant !== e_dma) begin bad++; $display("FAIL speed2_dma k=%0d got=%b exp=%b", k, dma_grant, e_dma); end
            if (k == 69) req = 2'b00;
        end
    endtask

    task automatic test_speed_change();
        int   f;
        int   idx;
        int   n_cpu;
        logic e_cpu;
        speed = 2'd0; pause = 1'b0; req = 2'b00;
        do_reset();
        for (int k = 1; k <= 170; k++) begin
            @(negedge clk);
            f     = k / 16;
            idx   = (f - 1) % 4;
            n_cpu = (f <= 4) ? 1 : ((f <= 8) ? 2 : 3);
            e_cpu = (f >= 1) && ((k % 16) == 0) && (idx < n_cpu);
            total++; if (cpu_grant !== e_cpu) begin bad++; $display("FAIL speedchg_cpu k=%0d got=%b exp=%b", k, cpu_grant, e_cpu); end
            if (k == 33) speed = 2'd1;
            if (k == 84) speed = 2'd2;
        end
    endtask

    // Pause raised on cycle 5 of the second CPU frame, released mid-group.
    task automatic test_pause();
        int         f;
        int         idx;
        logic       cpu_frame;
        logic       e_cpu;
        logic       e_paused;
        logic [1:0] e_dma;
        speed = 2'd2; pause = 1'b0; req = 2'b01;
        do_reset();
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            f         = k / 16;
            idx       = (f - 1) % 4;
            cpu_frame = (f >= 1) && (idx < 3) && !((f >= 3) && (f <= 6));
            e_cpu     = cpu_frame && ((k % 16) == 0);
            e_dma     = ((f >= 1) && !cpu_frame) ? 2'b01 : 2'b00;
            e_paused  = (k >= 48) && (k <= 100);
            total++; if (cpu_grant !== e_cpu)  begin bad++; $display("FAIL pause_cpu k=%0d got=%b exp=%b", k, cpu_grant, e_cpu); end
            total++; if (dma_grant !== e_dma)  begin bad++; $display("FAIL pause_dma k=%0d got=%b exp=%b", k, dma_grant, e_dma); end
            total++; if (paused !== e_paused)  begin bad++; $display("FAIL pause_flag k=%0d got=%b exp=%b", k, paused, e_paused); end
            if (k == 37)  pause = 1'b1;
            if (k == 100) pause = 1'b0;
        end
    endtask

    task automatic test_starve();
        int         f;
        int         idx;
        int         n;
        logic       e_cpu;
        logic [1:0] e_dma;
        speed = 2'd0; pause = 1'b0; req = 2'b11;
        n = -1;
        do_reset();
        for (int k = 1; k <= 336; k++) begin
            @(negedge clk);
            f   = k / 16;
            idx = (f - 1) % 4;
            if ((f >= 1) && ((k % 16) == 0) && (idx != 0)) n++;
            e_cpu = (f >= 1) && ((k % 16) == 0) && (idx == 0);
            if ((f < 1) || (idx == 0)) e_dma = 2'b00;
`ifdef BUS_SCHED_STARVE_EN
            else e_dma = ((n % 5) == 4) ? 2'b10 : 2'b01;
`else
            else e_dma = 2'b01;
`endif
            total++; if (cpu_grant !== e_cpu) begin bad++; $display("FAIL starve_cpu k=%0d got=%b exp=%b", k, cpu_grant, e_cpu); end
            total++; if (dma_grant !== e_dma) begin bad++; $display("FAIL starve_dma k=%0d got=%b exp=%b", k, dma_grant, e_dma); end
        end
    endtask

    // Reset on cycle 7 of a DMA frame: grants drop at once, then one idle frame.
    task automatic test_reset_mid();
        int         f;
        int         idx;
        logic       e_cpu;
        logic [1:0] e_dma;
        speed = 2'd0; pause = 1'b0; req = 2'b01;
        do_reset();
        repeat (39) @(negedge clk);
        total++; if (dma_grant !== 2'b01) begin bad++; $display("FAIL midrst_pre_dma got=%b exp=01", dma_grant); end
        total++; if (fcycle !== 4'd7)     begin bad++; $display("FAIL midrst_pre_cycle got=%0d exp=7", fcycle); end
        rst_n = 1'b0;
        #1;
        total++; if (dma_grant !== 2'b00) begin bad++; $display("FAIL midrst_async_dma got=%b exp=00", dma_grant); end
        total++; if (fcycle !== 4'd0)     begin bad++; $display("FAIL midrst_async_cycle got=%0d exp=0", fcycle); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            f     = k / 16;
            idx   = (f - 1) % 4;
            e_cpu = (k == 16);
            e_dma = ((f >= 1) && (idx != 0)) ? 2'b01 : 2'b00;
            total++; if (cpu_grant !== e_cpu) begin bad++; $display("FAIL midrst_cpu k=%0d got=%b exp=%b", k, cpu_grant, e_cpu); end
            total++; if (dma_grant !== e_dma) begin bad++; $display("FAIL midrst_dma k=%0d got=%b exp=%b", k, dma_grant, e_dma); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        speed = 2'd0;
        pause = 1'b0;
        req   = 2'b00;
        test_reset();
        test_speed0();
        test_speed2_dma0();
        test_speed_change();
        test_pause();
        test_starve();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
